// File: rtl/rca_acc_pkg.sv
// rca_acc_pkg: shared types, constants and sizing helper for the frame accumulator
package rca_acc_pkg;

   typedef enum logic [1:0] {S_ACCEPT, S_ADD, S_OUT} acc_state_t;

   localparam int BYTE_W = 8;

   function automatic int cnt_width(input int max_ops);
      return $clog2(max_ops + 1);
   endfunction

endpackage

// File: rtl/rca_2op_8bit.sv
// rca_2op_8bit: combinational 8-bit ripple-carry adder, S[8] is the carry out
module rca_2op_8bit (
   input  logic [7:0] A,
   input  logic [7:0] B,
   input  logic       Cin,
   output logic [8:0] S
);

   logic [8:0] c;

   assign c[0] = Cin;

   for (genvar i = 0; i < 8; i++) begin : g_fa
      assign S[i]   = A[i] ^ B[i] ^ c[i];
      assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
   end

   assign S[8] = c[8];

endmodule

// File: rtl/rca_frame_accumulator.sv
// rca_frame_accumulator: sums a frame of bytes into an ACC_W accumulator, one adder byte per cycle
module rca_frame_accumulator
   import rca_acc_pkg::*;
#(
   parameter int ACC_BYTES = 2,
   parameter int MAX_OPS   = 16,
   localparam int ACC_W    = BYTE_W * ACC_BYTES,
   localparam int CNT_W    = cnt_width(MAX_OPS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [7:0]       in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic             out_ovf,
   output logic [CNT_W-1:0] out_count
);

   localparam int IDX_W = (ACC_BYTES > 1) ? $clog2(ACC_BYTES) : 1;

   acc_state_t       state, state_n;
   logic [ACC_W-1:0] acc;
   logic             carry;
   logic [IDX_W-1:0] k;
   logic [7:0]       op;
   logic             last;
   logic             ovf;
   logic [CNT_W-1:0] count;
   logic [7:0]       a_byte;
   logic [7:0]       b_byte;
   logic             cin;
   logic [8:0]       s;
   logic             last_byte;

   assign last_byte = (k == IDX_W'(ACC_BYTES - 1));
   assign b_byte    = (k == '0) ? op : 8'h00;
   assign cin       = (k == '0) ? 1'b0 : carry;

   // select the accumulator byte currently being updated
   always_comb begin
      a_byte = '0;
      for (int i = 0; i < ACC_BYTES; i++)
         if (k == IDX_W'(i)) a_byte = acc[i*BYTE_W +: BYTE_W];
   end

   rca_2op_8bit u_add (
      .A   (a_byte),
      .B   (b_byte),
      .Cin (cin),
      .S   (s)
   );

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= S_ACCEPT;
      else     state <= state_n;
   end

   // next-state and handshake outputs
   always_comb begin
      state_n   = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         S_ACCEPT: begin
            in_ready = 1'b1;
            if (in_valid) state_n = S_ADD;
         end
         S_ADD: if (last_byte) state_n = last ? S_OUT : S_ACCEPT;
         S_OUT: begin
            out_valid = 1'b1;
            if (out_ready) state_n = S_ACCEPT;
         end
         default: state_n = S_ACCEPT;
      endcase
   end

   // datapath: operand latch, byte-serial accumulate, sticky overflow, saturating count
   always_ff @(posedge clk) begin
      if (rst) begin
         acc   <= '0;
         carry <= 1'b0;
         k     <= '0;
         op    <= '0;
         last  <= 1'b0;
         ovf   <= 1'b0;
         count <= '0;
      end else begin
         case (state)
            S_ACCEPT: if (in_valid) begin
               op    <= in_data;
               last  <= in_last;
               k     <= '0;
               count <= (count == CNT_W'(MAX_OPS)) ? count : count + CNT_W'(1);
            end
            S_ADD: begin
               for (int i = 0; i < ACC_BYTES; i++)
                  if (k == IDX_W'(i)) acc[i*BYTE_W +: BYTE_W] <= s[7:0];
               carry <= s[8];
               if (last_byte) ovf <= ovf | s[8];
               else           k   <= k + IDX_W'(1);
            end
            S_OUT: if (out_ready) begin
               acc   <= '0;
               ovf   <= 1'b0;
               count <= '0;
               carry <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign out_sum   = acc;
   assign out_ovf   = ovf;
   assign out_count = count;

endmodule

// File: tb/tb_rca_frame_accumulator.sv
// tb_rca_frame_accumulator: directed and randomized checks over four accumulator configurations
module tb_rca_frame_accumulator;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic       in_last;
   logic       out_ready;
   logic [7:0] in_data;
   int         sel;
   int         tests = 0;
   int         fails = 0;

   logic [3:0]  ivld, rdy, vld, ovf;
   logic [15:0] sum0;
   logic [7:0]  sum1;
   logic [15:0] sum2;
   logic [31:0] sum3;
   logic [4:0]  cnt0, cnt1, cnt3;
   logic [2:0]  cnt2;

   logic [31:0] c_sum;
   logic [7:0]  c_cnt;
   logic        c_rdy, c_vld, c_ovf;

   always #5 clk = ~clk;

   assign ivld = in_valid ? 4'(1 << sel) : 4'd0;

   rca_frame_accumulator #(.ACC_BYTES(2), .MAX_OPS(16)) u0 (
      .clk(clk), .rst(rst), .in_valid(ivld[0]), .in_ready(rdy[0]), .in_data(in_data),
      .in_last(in_last), .out_valid(vld[0]), .out_ready(out_ready), .out_sum(sum0),
      .out_ovf(ovf[0]), .out_count(cnt0));

   rca_frame_accumulator #(.ACC_BYTES(1), .MAX_OPS(16)) u1 (
      .clk(clk), .rst(rst), .in_valid(ivld[1]), .in_ready(rdy[1]), .in_data(in_data),
      .in_last(in_last), .out_valid(vld[1]), .out_ready(out_ready), .out_sum(sum1),
      .out_ovf(ovf[1]), .out_count(cnt1));

   rca_frame_accumulator #(.ACC_BYTES(2), .MAX_OPS(4)) u2 (
      .clk(clk), .rst(rst), .in_valid(ivld[2]), .in_ready(rdy[2]), .in_data(in_data),
      .in_last(in_last), .out_valid(vld[2]), .out_ready(out_ready), .out_sum(sum2),
      .out_ovf(ovf[2]), .out_count(cnt2));

   rca_frame_accumulator #(.ACC_BYTES(4), .MAX_OPS(16)) u3 (
      .clk(clk), .rst(rst), .in_valid(ivld[3]), .in_ready(rdy[3]), .in_data(in_data),
      .in_last(in_last), .out_valid(vld[3]), .out_ready(out_ready), .out_sum(sum3),
      .out_ovf(ovf[3]), .out_count(cnt3));

   // view of the currently selected DUT
   always_comb begin
      c_rdy = rdy[sel];
      c_vld = vld[sel];
      c_ovf = ovf[sel];
      case (sel)
         0:       begin c_sum = 32'(sum0); c_cnt = 8'(cnt0); end
         1:       begin c_sum = 32'(sum1); c_cnt = 8'(cnt1); end
         2:       begin c_sum = 32'(sum2); c_cnt = 8'(cnt2); end
         default: begin c_sum = sum3;      c_cnt = 8'(cnt3); end
      endcase
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic l);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!c_rdy && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", 64'(c_rdy), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_out(output int n);
      n = 0;
      while (!c_vld && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("out_timeout", 64'(c_vld), 64'd1);
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic result(input string tag, input logic [31:0] s, input logic o, input logic [7:0] c);
      check({tag, "_sum"}, 64'(c_sum), 64'(s));
      check({tag, "_ovf"}, 64'(c_ovf), 64'(o));
      check({tag, "_cnt"}, 64'(c_cnt), 64'(c));
   endtask

   initial begin
      int          lat;
      int          ab;
      int          nops;
      int          dsel;
      logic [7:0]  b;
      longint      tot;
      longint      modv;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      sel       = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_in_ready", 64'(c_rdy), 64'd1);
      check("rst_out_valid", 64'(c_vld), 64'd0);
      result("rst", 32'h0, 1'b0, 8'd0);

      // single operand frame, latency ACC_BYTES
      send(8'hFF, 1'b1);
      check("add_in_ready", 64'(c_rdy), 64'd0);
      wait_out(lat);
      check("latency", 64'(lat), 64'd2);
      result("single", 32'h00FF, 1'b0, 8'd1);
      take();

      // carry into the high byte
      send(8'hFF, 1'b0);
      send(8'h01, 1'b1);
      wait_out(lat);
      result("carry", 32'h0100, 1'b0, 8'd2);
      take();

      // one-byte accumulator wraps and flags overflow
      sel = 1;
      send(8'hF0, 1'b0);
      send(8'h20, 1'b1);
      wait_out(lat);
      result("wrap", 32'h10, 1'b1, 8'd2);
      take();
      send(8'h01, 1'b1);
      wait_out(lat);
      result("ovf_clear", 32'h01, 1'b0, 8'd1);
      take();

      // count saturates at MAX_OPS=4, sum keeps going
      sel = 2;
      for (int i = 0; i < 6; i++) send(8'h01, i == 5);
      wait_out(lat);
      result("sat", 32'h0006, 1'b0, 8'd4);
      take();

      // backpressure: result held, input ignored
      sel = 0;
      send(8'h03, 1'b0);
      send(8'h04, 1'b1);
      wait_out(lat);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(i * 37 + 9);
         in_last  = i[0];
         check("hold_valid", 64'(c_vld), 64'd1);
         check("hold_in_ready", 64'(c_rdy), 64'd0);
         result("hold", 32'h0007, 1'b0, 8'd2);
         @(negedge clk);
      end
      in_valid = 1'b0;
      take();
      check("post_take_ready", 64'(c_rdy), 64'd1);
      check("post_take_valid", 64'(c_vld), 64'd0);
      send(8'h02, 1'b1);
      wait_out(lat);
      result("after_clear", 32'h0002, 1'b0, 8'd1);
      take();

      // reset during the add phase of the second operand
      send(8'h05, 1'b0);
      send(8'h07, 1'b1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_in_ready", 64'(c_rdy), 64'd1);
      check("midrst_out_valid", 64'(c_vld), 64'd0);
      result("midrst", 32'h0, 1'b0, 8'd0);
      send(8'h05, 1'b1);
      wait_out(lat);
      result("post_rst", 32'h0005, 1'b0, 8'd1);
      take();

      // randomized frames with gaps against a reference sum
      for (int f = 0; f < 6; f++) begin
         for (int j = 0; j < 3; j++) begin
            dsel = (j == 0) ? 0 : (j == 1) ? 1 : 3;
            ab   = (j == 0) ? 2 : (j == 1) ? 1 : 4;
            sel  = dsel;
            nops = $urandom_range(1, 20);
            tot  = 0;
            for (int n = 0; n < nops; n++) begin
               b   = 8'($urandom_range(0, 255));
               tot += longint'(b);
               repeat ($urandom_range(0, 3)) @(negedge clk);
               send(b, n == nops - 1);
            end
            wait_out(lat);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            modv = longint'(1) << (8 * ab);
            result("rand", 32'(tot % modv), tot >= modv, 8'((nops > 16) ? 16 : nops));
            take();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
